vdp_sprite_line_scanner: RTL and testbench

// Parametrised next-generation sprite raster scanner for the VDP sprite path. Each line it scans the

---
 rtl/vdp_sprite_line_scanner_if.sv | 24 ++
 rtl/vdp_sprite_line_scanner.sv | 147 ++++++++++++++
 tb/tb_vdp_sprite_line_scanner.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/vdp_sprite_line_scanner_if.sv
// Scanner-side bus: Y attribute fetch, start/raster control, renderer hit-list read port and status.
interface vdp_sprite_line_scanner_if #(
    parameter int Y_WIDTH = 9
);
    logic               start_new_line;
    logic [Y_WIDTH-1:0] render_y;
    logic [7:0]         y_read_address;
    logic [15:0]        y_read_data;
    logic [7:0]         hl_read_address;
    logic [15:0]        hl_read_data;
    logic               busy;
    logic               line_overflow;
    logic [7:0]         hit_count;

    modport slave (
        input  start_new_line, render_y, y_read_data, hl_read_address,
        output y_read_address, hl_read_data, busy, line_overflow, hit_count
    );

    modport master (
        output start_new_line, render_y, y_read_data, hl_read_address,
        input  y_read_address, hl_read_data, busy, line_overflow, hit_count
    );
endinterface

// File: rtl/vdp_sprite_line_scanner.sv
// Per-line sprite Y scanner: tests every sprite against render_y and builds a
// double-buffered hit list (fill bank written by the scan, read bank served to the renderer).
module vdp_sprite_line_scanner #(
    parameter int SPRITE_COUNT = 256,
    parameter int MAX_PER_LINE = 64,
    parameter int Y_WIDTH      = 9
) (
    input  logic                        clk,
    input  logic                        reset_n,
    vdp_sprite_line_scanner_if.slave    bus
);
    localparam int          DEPTH      = MAX_PER_LINE + 1;
    localparam int          AW         = $clog2(DEPTH);
    localparam logic [8:0]  LAST_IDX   = 9'(SPRITE_COUNT);
    localparam logic [8:0]  DEPTH9     = 9'(DEPTH);
    localparam logic [7:0]  MAX_CNT    = 8'(MAX_PER_LINE);
    localparam logic [15:0] TERM_ENTRY = 16'h8000;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_TERM} state_e;

    state_e      state_q, state_d;
    logic [8:0]  idx_q, idx_d;
    logic        fill_q, fill_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        ovf_q, ovf_d;
    logic        rdv_q, rdv_d;
    logic [7:0]  hc_q, hc_d;
    logic        lo_q, lo_d;
    logic [15:0] rd_data_q;
    logic [15:0] mem_q [2][DEPTH];

    logic        we;
    logic        wbank;
    logic [7:0]  widx;
    logic [15:0] wdata;

    // Hit test on the attribute returned for the id addressed last cycle
    logic [Y_WIDTH-1:0] delta;
    logic [6:0]         height, off_flip;
    logic [5:0]         offset;
    logic [8:0]         prev_idx;
    logic               hit;
    logic [15:0]        entry;
    logic               unused_bits;

    assign delta    = bus.render_y - bus.y_read_data[Y_WIDTH-1:0];
    assign height   = 7'd8 << bus.y_read_data[14:13];
    assign hit      = delta < {{(Y_WIDTH-7){1'b0}}, height};
    assign off_flip = height - 7'd1 - delta[6:0];
    assign offset   = bus.y_read_data[12] ? off_flip[5:0] : delta[5:0];
    assign prev_idx = idx_q - 9'd1;
    assign entry    = {1'b0, bus.y_read_data[15], offset, prev_idx[7:0]};
    assign unused_bits = ^bus.y_read_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            fill_q  <= 1'b0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            rdv_q   <= 1'b0;
            hc_q    <= '0;
            lo_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            rdv_q   <= rdv_d;
            hc_q    <= hc_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        rdv_d   = rdv_q;
        hc_d    = hc_q;
        lo_d    = lo_q;
        we      = 1'b0;
        wbank   = fill_q;
        widx    = cnt_q;
        wdata   = TERM_ENTRY;

        if (bus.start_new_line) begin
            // Abort seals the pre-swap bank with a terminator and flags it truncated
            if (state_q != S_IDLE) we = 1'b1;
            lo_d    = ovf_q | (state_q != S_IDLE);
            hc_d    = cnt_q;
            fill_d  = ~fill_q;
            rdv_d   = 1'b1;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            idx_d   = '0;
            state_d = S_SCAN;
        end else begin
            case (state_q)
                S_SCAN: begin
                    idx_d = idx_q + 9'd1;
                    if (idx_q == LAST_IDX) state_d = S_TERM;
                    if (idx_q != 9'd0 && hit) begin
                        we = 1'b1;
                        if (cnt_q == MAX_CNT) begin
                            // Overflow cycle doubles as the terminator write
                            ovf_d   = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            wdata = entry;
                            cnt_d = cnt_q + 8'd1;
                        end
                    end
                end
                S_TERM: begin
                    we      = 1'b1;
                    idx_d   = '0;
                    state_d = S_IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem_q[wbank][widx[AW-1:0]] <= wdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            rd_data_q <= TERM_ENTRY;
        else if (!rdv_q || {1'b0, bus.hl_read_address} >= DEPTH9)
            rd_data_q <= TERM_ENTRY;
        else
            rd_data_q <= mem_q[~fill_q][bus.hl_read_address[AW-1:0]];
    end

    assign bus.y_read_address = idx_q[7:0];
    assign bus.hl_read_data   = rd_data_q;
    assign bus.busy           = (state_q != S_IDLE);
    assign bus.line_overflow  = lo_q;
    assign bus.hit_count      = hc_q;
endmodule

// File: tb/tb_vdp_sprite_line_scanner.sv
// Directed bench: main scanner (256 sprites, limit 64) and a small one (16 sprites, limit 4).
module tb_vdp_sprite_line_scanner;
    logic clk = 1'b0;
    logic reset_n;
    int   n_vec = 0;
    int   n_err = 0;
    logic [15:0] yram [256];

    always #5 clk = ~clk;

    vdp_sprite_line_scanner_if #(.Y_WIDTH(9)) bm ();
    vdp_sprite_line_scanner_if #(.Y_WIDTH(9)) bs ();

    vdp_sprite_line_scanner #(.SPRITE_COUNT(256), .MAX_PER_LINE(64), .Y_WIDTH(9)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bm.slave));

    vdp_sprite_line_scanner #(.SPRITE_COUNT(16), .MAX_PER_LINE(4), .Y_WIDTH(9)) dut_s (
        .clk(clk), .reset_n(reset_n), .bus(bs.slave));

    // Synchronous Y attribute RAM: data one cycle after address
    always @(posedge clk) bm.y_read_data <= yram[bm.y_read_address];
    // Every small-scanner sprite: y=50, h=8, flip=1
    assign bs.y_read_data = 16'h1032;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rd_m(input logic [7:0] a, output logic [15:0] d);
        @(negedge clk) bm.hl_read_address = a;
        @(posedge clk); #1 d = bm.hl_read_data;
    endtask

    task automatic rd_s(input logic [7:0] a, output logic [15:0] d);
        @(negedge clk) bs.hl_read_address = a;
        @(posedge clk); #1 d = bs.hl_read_data;
    endtask

    task automatic pulse_m(input bit wait_done, output int cyc);
        @(negedge clk) bm.start_new_line = 1'b1;
        @(posedge clk); #1 bm.start_new_line = 1'b0;
        cyc = 0;
        if (wait_done)
            while (bm.busy && cyc < 400) begin
                cyc++;
                @(posedge clk); #1;
            end
    endtask

    task automatic pulse_s(output int cyc);
        @(negedge clk) bs.start_new_line = 1'b1;
        @(posedge clk); #1 bs.start_new_line = 1'b0;
        cyc = 0;
        while (bs.busy && cyc < 100) begin
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [15:0] d;
        int cyc;
        reset_n = 1'b0;
        bm.start_new_line = 1'b0; bm.render_y = 9'd100; bm.hl_read_address = 8'd0;
        bs.start_new_line = 1'b0; bs.render_y = 9'd50;  bs.hl_read_address = 8'd0;
        for (int i = 0; i < 256; i++) yram[i] = 16'd400;
        yram[3] = 16'h2000 | 16'd95;
        yram[7] = 16'h1000 | 16'd100;
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;

        // Reset state
        rd_m(8'd0, d);
        chk("rst_hl_data", d, 16'h8000);
        chk("rst_busy", bm.busy, 1'b0);
        chk("rst_hit_count", bm.hit_count, 8'd0);
        chk("rst_overflow", bm.line_overflow, 1'b0);
        chk("rst_y_addr", bm.y_read_address, 8'd0);

        // Basic line: ids 3 and 7 hit
        pulse_m(1'b1, cyc);
        chk("scan_cycles_a", cyc, 258);
        // Next line's data loaded while idle: wrap, h64 flip + width, one late hit
        bm.render_y = 9'd5;
        yram[3] = 16'd400; yram[7] = 16'd400;
        yram[10]  = 16'h4000 | 16'd508;
        yram[11]  = 16'd508;
        yram[20]  = 16'hF005;
        yram[100] = 16'd5;
        pulse_m(1'b1, cyc);
        chk("scan_cycles_b", cyc, 258);
        chk("basic_hit_count", bm.hit_count, 8'd2);
        chk("basic_overflow", bm.line_overflow, 1'b0);
        rd_m(8'd0, d); chk("basic_e0", d, 16'h0503);
        rd_m(8'd1, d); chk("basic_e1", d, 16'h0707);
        rd_m(8'd2, d); chk("basic_term", d, 16'h8000);

        // Wrap line read back while the next scan runs
        pulse_m(1'b0, cyc);
        chk("wrap_hit_count", bm.hit_count, 8'd3);
        chk("wrap_overflow", bm.line_overflow, 1'b0);
        rd_m(8'd0, d);   chk("wrap_e0", d, 16'h090A);
        rd_m(8'd1, d);   chk("h64_flip_e1", d, 16'h7F14);
        rd_m(8'd2, d);   chk("wrap_e2", d, 16'h0064);
        rd_m(8'd3, d);   chk("wrap_term", d, 16'h8000);
        rd_m(8'd65, d);  chk("oob_65", d, 16'h8000);
        rd_m(8'd255, d); chk("oob_255", d, 16'h8000);
        chk("busy_mid_scan", bm.busy, 1'b1);

        // Abort about 40 cycles into the scan: ids 10 and 20 found, id 100 not yet
        repeat (30) @(posedge clk);
        pulse_m(1'b1, cyc);
        chk("scan_cycles_abort", cyc, 258);
        chk("abort_hit_count", bm.hit_count, 8'd2);
        chk("abort_overflow", bm.line_overflow, 1'b1);
        rd_m(8'd0, d); chk("abort_e0", d, 16'h090A);
        rd_m(8'd1, d); chk("abort_e1", d, 16'h7F14);
        rd_m(8'd2, d); chk("abort_term", d, 16'h8000);

        // Following full line is clean
        pulse_m(1'b1, cyc);
        chk("after_hit_count", bm.hit_count, 8'd3);
        chk("after_overflow", bm.line_overflow, 1'b0);
        rd_m(8'd2, d); chk("after_e2", d, 16'h0064);
        rd_m(8'd3, d); chk("after_term", d, 16'h8000);

        // Limit of 4 with every sprite hitting
        pulse_s(cyc);
        chk("limit_scan_cycles", cyc, 6);
        pulse_s(cyc);
        chk("limit_hit_count", bs.hit_count, 8'd4);
        chk("limit_overflow", bs.line_overflow, 1'b1);
        for (int i = 0; i < 4; i++) begin
            rd_s(8'(i), d);
            chk("limit_entry", d, 32'h0700 | i);
        end
        rd_s(8'd4, d); chk("limit_term", d, 16'h8000);
        rd_s(8'd5, d); chk("limit_oob", d, 16'h8000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
